gate_tx_serializer: RTL and testbench
=====================================

// Module: gate_tx_serializer
// PURPOSE
//   Per-gate transmit channel; one instance per gate, driven by the network sequencer.
//   Sequencer side: i_gen_sync and i_tx_start in; o_tx_ready back to its i_tx_ready[g].
//   Each i_tx_start launches one serial frame of i_data (start, data LSB-first, even parity, stop).
//   o_tx_ready is deasserted for the whole frame and reasserts when the line is idle again.
// PARAMETERS
//   DATA_WIDTH  8  payload bits per frame (>=1)
//   BIT_CYCLES  4  i_clk cycles per serial bit (>=1)
// PORTS
//   i_clk         in   1           single clock, all logic on posedge
//   i_rst_n       in   1           asynchronous, active-low reset
//   i_gen_sync    in   1           sequencer sync: abort frame, clear flags/counter
//   i_tx_start    in   1           1-cycle launch request
//   i_data        in   DATA_WIDTH  payload, sampled on accepted i_tx_start
//   o_tx_ready    out  1           1 = idle, can accept i_tx_start
//   o_serial      out  1           serial line, idle high
//   o_overrun     out  1           sticky: i_tx_start seen while busy
//   o_frame_cnt   out  8           completed-frame counter, wraps 255->0
// BEHAVIOUR
//   Reset (i_rst_n=0, async): state IDLE, o_tx_ready=1, o_serial=1, o_overrun=0, o_frame_cnt=0.
//   All outputs registered. FRAME_LEN = (DATA_WIDTH+3)*BIT_CYCLES cycles.
//   States:
//   - IDLE: o_serial=1, o_tx_ready=1.
//   - START: o_serial=0.
//   - DATA: bit k = shadow[k], k=0..DATA_WIDTH-1.
//   - PARITY: o_serial = ^shadow (even parity).
//   - STOP: o_serial=1.
//   Every non-IDLE bit state holds for exactly BIT_CYCLES cycles (bit-cycle counter 0..BIT_CYCLES-1).
//   IDLE->START: i_tx_start=1 and i_gen_sync=0 in edge N.
//   - i_data latched into shadow reg at edge N.
//   - At N+1: o_serial=0, o_tx_ready=0.
//   - Data bit k occupies cycles N+1+(k+1)*BIT_CYCLES ...
//   STOP->IDLE: after last STOP cycle.
//   - o_tx_ready=1 and o_frame_cnt+1 both visible at N+1+FRAME_LEN.
//   Back-to-back: i_tx_start in the first ready cycle is accepted. No idle gap is required beyond that cycle.
//   i_tx_start while busy: ignored; frame and shadow unaffected; o_overrun<=1 next cycle.
//   i_gen_sync=1 (any state), at the next edge:
//   - state IDLE, o_serial=1, o_tx_ready=1, o_overrun=0, o_frame_cnt=0.
//   - Aborted frame is not counted.
//   i_gen_sync and i_tx_start in the same cycle: sync wins. Start dropped, no overrun.
//   i_data changes mid-frame: no effect; only shadow is transmitted.
//   o_frame_cnt wraps 8'hFF -> 8'h00 without flag.
//   Async reset mid-frame: immediate return to reset values. Line goes high without a stop bit.
// TESTING (DATA_WIDTH=8, BIT_CYCLES=4, FRAME_LEN=44)
//   1. Reset release, no stimulus -> o_serial=1, o_tx_ready=1, o_overrun=0, o_frame_cnt=0 for 100 cycles.
//   2. i_tx_start with i_data=8'hA5 at edge N:
//      - o_serial = 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each held 4 cycles from N+1.
//      - o_tx_ready=0 during N+1..N+44, =1 at N+45.
//      - o_frame_cnt=1.
//   3. i_data=8'h07, then i_tx_start in the first ready cycle, i_data=8'hFF:
//      - second frame starts with no gap; parity bits 1 then 0.
//      - o_frame_cnt=2.
//   4. i_tx_start again 10 cycles into a frame -> frame unchanged, o_overrun=1.
//      - Then i_gen_sync -> o_overrun=0, o_frame_cnt=0 next cycle.
//   5. i_gen_sync and i_tx_start same cycle in IDLE -> no frame, o_tx_ready stays 1, o_overrun=0.
//      - i_gen_sync at cycle 20 of a frame -> o_serial=1, ready=1 next cycle, count unchanged (0).
//   6. Drive 256 frames -> o_frame_cnt wraps to 0.
//      - Assert i_rst_n=0 mid-frame -> outputs at reset values with no clock edge.

Source files
------------

// File: rtl/gate_tx_serializer.sv
// Per-gate serial transmit channel: one frame (start, LSB-first data, even parity, stop) per accepted i_tx_start.
// Latency: line drops to the start bit one cycle after acceptance; o_tx_ready returns FRAME_LEN cycles after that.
// Backpressure: o_tx_ready low for the whole frame; i_tx_start while busy is dropped and flagged on o_overrun.
//
// Ports:
//   i_clk        - single clock, all logic on posedge
//   i_rst_n      - asynchronous active-low reset
//   i_gen_sync   - sequencer sync: aborts any frame, clears o_overrun and o_frame_cnt
//   i_tx_start   - one-cycle launch request, honoured only while idle
//   i_data       - payload, captured when i_tx_start is accepted
//   o_tx_ready   - 1 while idle and able to accept i_tx_start
//   o_serial     - serial line, idle high
//   o_overrun    - sticky, set when i_tx_start arrives while busy
//   o_frame_cnt  - count of completed frames, wraps 255 -> 0
module gate_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_gen_sync,
  input  logic                  i_tx_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_tx_ready,
  output logic                  o_serial,
  output logic                  o_overrun,
  output logic [7:0]            o_frame_cnt
);

  // Counter widths are held at >= 1 so DATA_WIDTH=1 / BIT_CYCLES=1 still elaborate.
  localparam int BC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int DI_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state;
  logic [BC_W-1:0]       bit_cnt;
  logic [DI_W-1:0]       data_idx;
  // Shift copy of the captured payload; the next data bit is always at [0].
  logic [DATA_WIDTH-1:0] shadow;
  logic                  parity_bit;
  logic                  bit_last;

  assign bit_last = (bit_cnt == BC_W'(BIT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      data_idx    <= '0;
      shadow      <= '0;
      parity_bit  <= 1'b0;
      o_tx_ready  <= 1'b1;
      o_serial    <= 1'b1;
      o_overrun   <= 1'b0;
      o_frame_cnt <= 8'd0;
    end else if (i_gen_sync) begin
      // Sync wins over everything, including a same-cycle start request.
      state       <= S_IDLE;
      bit_cnt     <= '0;
      data_idx    <= '0;
      o_tx_ready  <= 1'b1;
      o_serial    <= 1'b1;
      o_overrun   <= 1'b0;
      o_frame_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_tx_start) begin
            shadow     <= i_data;
            parity_bit <= ^i_data;
            state      <= S_START;
            bit_cnt    <= '0;
            data_idx   <= '0;
            o_serial   <= 1'b0;
            o_tx_ready <= 1'b0;
          end
        end

        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (i_tx_start) begin
            o_overrun <= 1'b1;
          end
          if (!bit_last) begin
            bit_cnt <= bit_cnt + BC_W'(1);
          end else begin
            bit_cnt <= '0;
            case (state)
              S_START: begin
                state    <= S_DATA;
                o_serial <= shadow[0];
                shadow   <= shadow >> 1;
              end
              S_DATA: begin
                if (data_idx == DI_W'(DATA_WIDTH - 1)) begin
                  state    <= S_PARITY;
                  o_serial <= parity_bit;
                end else begin
                  data_idx <= data_idx + DI_W'(1);
                  o_serial <= shadow[0];
                  shadow   <= shadow >> 1;
                end
              end
              S_PARITY: begin
                state    <= S_STOP;
                o_serial <= 1'b1;
              end
              default: begin
                // End of the stop bit: ready and the new count appear together.
                state       <= S_IDLE;
                o_serial    <= 1'b1;
                o_tx_ready  <= 1'b1;
                o_frame_cnt <= o_frame_cnt + 8'd1;
              end
            endcase
          end
        end

        default: begin
          state      <= S_IDLE;
          bit_cnt    <= '0;
          o_serial   <= 1'b1;
          o_tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tx_serializer.sv
module tb_gate_tx_serializer;

  localparam int FRAME_LEN = 44;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_gen_sync;
  logic       i_tx_start;
  logic [7:0] i_data;
  logic       o_tx_ready;
  logic       o_serial;
  logic       o_overrun;
  logic [7:0] o_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  gate_tx_serializer #(
    .DATA_WIDTH(8),
    .BIT_CYCLES(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_gen_sync (i_gen_sync),
    .i_tx_start (i_tx_start),
    .i_data     (i_data),
    .o_tx_ready (o_tx_ready),
    .o_serial   (o_serial),
    .o_overrun  (o_overrun),
    .o_frame_cnt(o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level in bit slot 0..10 of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge in a ready cycle. Launches d, runs the full frame and
  // returns at the negedge of its last cycle. poke_at>0 pulses i_tx_start at
  // that frame cycle to provoke an overrun.
  task automatic send_frame(input logic [7:0] d, input int poke_at, input bit quiet);
    i_tx_start = 1'b1;
    i_data     = d;
    @(posedge i_clk);
    for (int i = 1; i <= FRAME_LEN; i++) begin
      @(negedge i_clk);
      if (i == 1) begin
        i_tx_start = 1'b0;
        i_data     = ~d;
      end
      if (poke_at != 0 && i == poke_at) begin
        i_tx_start = 1'b1;
        i_data     = 8'h00;
      end
      if (poke_at != 0 && i == poke_at + 1) begin
        i_tx_start = 1'b0;
      end
      if (!quiet) begin
        chk($sformatf("serial d=%02h c%0d", d, i), o_serial, exp_bit(d, (i - 1) / 4));
        chk($sformatf("busy d=%02h c%0d", d, i), o_tx_ready, 1'b0);
        if (poke_at != 0)
          chk($sformatf("overrun d=%02h c%0d", d, i), o_overrun, (i > poke_at) ? 1 : 0);
      end
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_gen_sync = 1'b0;
    i_tx_start = 1'b0;
    i_data     = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst serial", o_serial, 1);
    chk("rst ready", o_tx_ready, 1);
    chk("rst overrun", o_overrun, 0);
    chk("rst cnt", o_frame_cnt, 0);
    i_rst_n = 1'b1;

    // 1. Idle after reset release.
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      chk("idle serial", o_serial, 1);
      chk("idle ready", o_tx_ready, 1);
      chk("idle overrun", o_overrun, 0);
      chk("idle cnt", o_frame_cnt, 0);
    end

    // 2. Single frame A5.
    send_frame(8'hA5, 0, 1'b0);
    @(negedge i_clk);
    chk("A5 ready after", o_tx_ready, 1);
    chk("A5 serial after", o_serial, 1);
    chk("A5 cnt", o_frame_cnt, 1);

    // 3. Back-to-back 07 then FF, each launched in the first ready cycle.
    send_frame(8'h07, 0, 1'b0);
    @(negedge i_clk);
    chk("07 ready after", o_tx_ready, 1);
    chk("07 cnt", o_frame_cnt, 2);
    send_frame(8'hFF, 0, 1'b0);
    @(negedge i_clk);
    chk("FF ready after", o_tx_ready, 1);
    chk("FF cnt", o_frame_cnt, 3);
    chk("FF no overrun", o_overrun, 0);

    // 4. Start request while busy, then sync.
    repeat (3) @(negedge i_clk);
    send_frame(8'h3C, 10, 1'b0);
    @(negedge i_clk);
    chk("3C cnt", o_frame_cnt, 4);
    chk("3C overrun sticky", o_overrun, 1);
    i_gen_sync = 1'b1;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    chk("sync overrun", o_overrun, 0);
    chk("sync cnt", o_frame_cnt, 0);
    chk("sync ready", o_tx_ready, 1);

    // 5a. Sync and start together while idle.
    i_gen_sync = 1'b1;
    i_tx_start = 1'b1;
    i_data     = 8'h55;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    i_tx_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("sync+start ready", o_tx_ready, 1);
      chk("sync+start serial", o_serial, 1);
      chk("sync+start overrun", o_overrun, 0);
      @(negedge i_clk);
    end

    // 5b. Sync at cycle 20 of a frame of 00.
    i_tx_start = 1'b1;
    i_data     = 8'h00;
    @(posedge i_clk);
    @(negedge i_clk);
    i_tx_start = 1'b0;
    repeat (19) @(negedge i_clk);
    chk("abort pre serial", o_serial, 0);
    chk("abort pre ready", o_tx_ready, 0);
    i_gen_sync = 1'b1;
    @(negedge i_clk);
    i_gen_sync = 1'b0;
    chk("abort serial", o_serial, 1);
    chk("abort ready", o_tx_ready, 1);
    chk("abort cnt", o_frame_cnt, 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(negedge i_clk);
      chk("abort idle serial", o_serial, 1);
    end
    chk("abort cnt later", o_frame_cnt, 0);

    // 6. 256 back-to-back frames wrap the counter.
    for (int f = 1; f <= 256; f++) begin
      send_frame(8'(f), 0, 1'b1);
      @(negedge i_clk);
      if (f == 1)   chk("wrap cnt 1", o_frame_cnt, 1);
      if (f == 255) chk("wrap cnt 255", o_frame_cnt, 255);
      if (f == 256) chk("wrap cnt 0", o_frame_cnt, 0);
    end
    send_frame(8'h81, 0, 1'b1);
    @(negedge i_clk);
    chk("post wrap cnt", o_frame_cnt, 1);

    // Async reset mid-frame, with overrun set and count nonzero.
    i_tx_start = 1'b1;
    i_data     = 8'hE1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_tx_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_tx_start = 1'b1;
    @(negedge i_clk);
    i_tx_start = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("pre-rst overrun", o_overrun, 1);
    chk("pre-rst ready", o_tx_ready, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async rst serial", o_serial, 1);
    chk("async rst ready", o_tx_ready, 1);
    chk("async rst overrun", o_overrun, 0);
    chk("async rst cnt", o_frame_cnt, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("post rst serial", o_serial, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
